// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch (i_*), load/store (d_*) and memory (m_*) signals of the
//   unified-memory arbiter.
//   Modports:
//     slave  - the arbiter: takes requests and m_rdata, drives grants,
//              responses and the memory command.
//     master - the environment: the core's fetch/LSU plus the memory model.
//   Parameters: WORD_SIZE (data/address width), MEM_SIZE (depth in words).
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 256
);
    localparam int AW = $clog2(MEM_SIZE);

    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_err;

    logic                 d_req;
    logic                 d_we;
    logic [3:0]           d_be;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_err;

    logic                 m_en;
    logic                 m_we;
    logic [3:0]           m_be;
    logic [AW-1:0]        m_addr;
    logic [WORD_SIZE-1:0] m_wdata;
    logic [WORD_SIZE-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_en, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_en, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, word-organised memory between instruction fetch
//   (I) and load/store (D). Grants are combinational in the request cycle;
//   every grant (read, store or error) yields exactly one response the next
//   cycle on the granted side.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset; also masks all grants while low
//     bus   - mem_port_arbiter_if.slave (i_*, d_*, m_* signal groups)
//   Arbitration:
//     default             - D over I, except that I wins once it has lost
//                           MAX_STALL consecutive cycles.
//     MEM_ARB_RR_EN       - round robin against last_owner on contention.
//   Errors (word >= MEM_SIZE, misaligned fetch, data with d_be == 0) are
//   still granted but never reach the memory.
module mem_port_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 256,
    parameter int MAX_STALL = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int WW = WORD_SIZE - 2;
    localparam logic [WW-1:0] MEM_WORDS = WW'(MEM_SIZE);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_I    = 2'd1,
        SEL_D    = 2'd2
    } sel_t;

    logic [WW-1:0] i_word;
    logic [WW-1:0] d_word;
    logic          i_bad;
    logic          d_bad;
    logic          pick_i_on_tie;
    logic          grant_i;
    logic          grant_d;

    logic                 m_en_c;
    logic                 m_we_c;
    logic [3:0]           m_be_c;
    logic [AW-1:0]        m_addr_c;
    logic [WORD_SIZE-1:0] m_wdata_c;

    sel_t rsp_sel;
    logic rsp_err;
    logic rsp_we;

    // Data byte offset is carried by d_be, not by the address.
    logic unused_d_addr_lo;
    assign unused_d_addr_lo = ^bus.d_addr[1:0];

    assign i_word = bus.i_addr[WORD_SIZE-1:2];
    assign d_word = bus.d_addr[WORD_SIZE-1:2];
    assign i_bad  = (i_word >= MEM_WORDS) || (bus.i_addr[1:0] != 2'b00);
    assign d_bad  = (d_word >= MEM_WORDS) || (bus.d_be == 4'b0000);

`ifdef MEM_ARB_RR_EN
    // last_owner: 0 = I, 1 = D. On a tie the side that did not win last goes.
    logic last_owner;

    assign pick_i_on_tie = last_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b0;
        end else if (grant_i) begin
            last_owner <= 1'b0;
        end else if (grant_d) begin
            last_owner <= 1'b1;
        end
    end
`else
    // Consecutive cycles I has waited; at MAX_STALL it overrides D.
    localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);
    logic [3:0] stall_cnt;

    assign pick_i_on_tie = (stall_cnt == STALL_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 4'd0;
        end else if (bus.i_req && !grant_i) begin
            if (stall_cnt != STALL_LIMIT) begin
                stall_cnt <= stall_cnt + 4'd1;
            end
        end else begin
            stall_cnt <= 4'd0;
        end
    end
`endif

    // Gating with rst_n keeps every output at 0 for the whole reset window,
    // not just after the registers clear.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n) begin
            if (bus.i_req && bus.d_req) begin
                grant_i = pick_i_on_tie;
                grant_d = !pick_i_on_tie;
            end else begin
                grant_i = bus.i_req;
                grant_d = bus.d_req;
            end
        end
    end

    always_comb begin
        m_en_c    = 1'b0;
        m_we_c    = 1'b0;
        m_be_c    = 4'h0;
        m_addr_c  = '0;
        m_wdata_c = '0;
        if (grant_i && !i_bad) begin
            m_en_c   = 1'b1;
            m_be_c   = 4'hF;
            m_addr_c = i_word[AW-1:0];
        end else if (grant_d && !d_bad) begin
            m_en_c    = 1'b1;
            m_we_c    = bus.d_we;
            m_be_c    = bus.d_be;
            m_addr_c  = d_word[AW-1:0];
            m_wdata_c = bus.d_wdata;
        end
    end

    assign bus.i_gnt   = grant_i;
    assign bus.d_gnt   = grant_d;
    assign bus.m_en    = m_en_c;
    assign bus.m_we    = m_we_c;
    assign bus.m_be    = m_be_c;
    assign bus.m_addr  = m_addr_c;
    assign bus.m_wdata = m_wdata_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sel <= SEL_NONE;
            rsp_err <= 1'b0;
            rsp_we  <= 1'b0;
        end else if (grant_i) begin
            rsp_sel <= SEL_I;
            rsp_err <= i_bad;
            rsp_we  <= 1'b0;
        end else if (grant_d) begin
            rsp_sel <= SEL_D;
            rsp_err <= d_bad;
            rsp_we  <= bus.d_we;
        end else begin
            rsp_sel <= SEL_NONE;
            rsp_err <= 1'b0;
            rsp_we  <= 1'b0;
        end
    end

    // m_rdata is only meaningful for a non-error read issued last cycle.
    assign bus.i_rvalid = (rsp_sel == SEL_I);
    assign bus.i_err    = (rsp_sel == SEL_I) && rsp_err;
    assign bus.i_rdata  = ((rsp_sel == SEL_I) && !rsp_err) ? bus.m_rdata : '0;
    assign bus.d_rvalid = (rsp_sel == SEL_D);
    assign bus.d_err    = (rsp_sel == SEL_D) && rsp_err;
    assign bus.d_rdata  = ((rsp_sel == SEL_D) && !rsp_err && !rsp_we) ? bus.m_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Table vectors for single transactions, hand sequences for contention and
//   reset, then constrained-random traffic checked every cycle against a
//   transaction-level reference model with its own shadow memory.
module tb_mem_port_arbiter;
    localparam int WORD_SIZE = 32;
    localparam int MEM_SIZE  = 256;
    localparam int MAX_STALL = 4;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.WORD_SIZE(WORD_SIZE), .MEM_SIZE(MEM_SIZE)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE(WORD_SIZE),
        .MEM_SIZE (MEM_SIZE),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read, byte-enabled write.
    logic [31:0] mem [MEM_SIZE];
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.m_be[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
                end
            end else begin
                bus.m_rdata <= mem[bus.m_addr];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [MEM_SIZE];
    bit          p_i, p_d, p_err;
    logic [31:0] p_data;
    int          m_win;   // 0 none, 1 I, 2 D
`ifdef MEM_ARB_RR_EN
    int          m_last;
`else
    int          m_stall;
`endif

    task automatic model_reset();
        p_i = 0; p_d = 0; p_err = 0; p_data = 32'h0; m_win = 0;
`ifdef MEM_ARB_RR_EN
        m_last = 1;
`else
        m_stall = 0;
`endif
    endtask

    // Called at the negedge with this cycle's inputs stable.
    task automatic model_step();
        logic [29:0] iw, dw;
        bit          ie, de, een, ewe;
        int          win;
        logic [3:0]  ebe;
        logic [7:0]  ea;
        logic [31:0] ewd;
        iw = bus.i_addr[31:2];
        dw = bus.d_addr[31:2];
        ie = (iw >= 30'(MEM_SIZE)) || (bus.i_addr[1:0] != 2'b00);
        de = (dw >= 30'(MEM_SIZE)) || (bus.d_be == 4'h0);
        if (bus.i_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
            win = (m_last == 2) ? 1 : 2;
`else
            win = (m_stall >= MAX_STALL) ? 1 : 2;
`endif
        end else if (bus.i_req) win = 1;
        else if (bus.d_req) win = 2;
        else win = 0;
        een = (win == 1 && !ie) || (win == 2 && !de);
        ewe = een && (win == 2) && bus.d_we;
        ebe = !een ? 4'h0 : ((win == 1) ? 4'hF : bus.d_be);
        ea  = !een ? 8'h0 : ((win == 1) ? 8'(iw % MEM_SIZE) : 8'(dw % MEM_SIZE));
        ewd = (een && win == 2) ? bus.d_wdata : 32'h0;

        chk("model_grant_side",
            {16'h0, bus.i_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata},
            {16'h0, win == 1, win == 2, een, ewe, ebe, ea, ewd});
        chk("model_i_response", {30'h0, bus.i_rvalid, bus.i_err, bus.i_rdata},
            {30'h0, p_i, p_i && p_err, p_i ? p_data : 32'h0});
        chk("model_d_response", {30'h0, bus.d_rvalid, bus.d_err, bus.d_rdata},
            {30'h0, p_d, p_d && p_err, p_d ? p_data : 32'h0});

        p_i    = (win == 1);
        p_d    = (win == 2);
        p_err  = (win == 1) ? ie : ((win == 2) ? de : 1'b0);
        p_data = 32'h0;
        if (een && !ewe) p_data = ref_mem[ea];
        if (ewe) begin
            for (int b = 0; b < 4; b++)
                if (ebe[b]) ref_mem[ea][8*b +: 8] = ewd[8*b +: 8];
        end
`ifdef MEM_ARB_RR_EN
        if (win != 0) m_last = win;
`else
        if (bus.i_req && win != 1) m_stall = (m_stall < MAX_STALL) ? m_stall + 1 : MAX_STALL;
        else m_stall = 0;
`endif
        m_win = win;
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_req = 0; bus.i_addr = 32'h0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant_side"},
            {16'h0, bus.i_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata}, 64'h0);
        chk({tag, "_flags"}, {60'h0, bus.i_rvalid, bus.i_err, bus.d_rvalid, bus.d_err}, 64'h0);
        chk({tag, "_rdata"}, {bus.i_rdata, bus.d_rdata}, 64'h0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_m_en;
        logic        e_m_we;
        logic [3:0]  e_m_be;
        logic [7:0]  e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_i_rv;
        logic        e_i_err;
        logic [31:0] e_i_rd;
        logic        e_d_rv;
        logic        e_d_err;
        logic [31:0] e_d_rd;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        rst_n = 1'b0;
        drive_idle();
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     <= 32'hC0DE_0000 | 32'(i);
            ref_mem[i]  = 32'hC0DE_0000 | 32'(i);
        end
        mem[4]     <= 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        model_reset();

        //            i_req  i_addr        d_req d_we  d_be  d_addr        d_wdata        ig    dg    en    we    be    ma     m_wdata        irv   ierr  i_rd           drv   derr  d_rd
        vecs[0]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd4,   32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0,   32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0400, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0,   32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_03FC, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 8'd255, 32'h0,         1'b1, 1'b0, 32'hC0DE_00FF, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF, 32'h0000_001C, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'd7,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC0DE_0007};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 4'h2, 32'h0000_0021, 32'h0000_AB00, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 8'd8,   32'h0000_AB00, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'd8,   32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC0DE_AB08};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h1, 32'h0000_0023, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 8'd8,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC0DE_AB08};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h0000_0404, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF, 32'h0000_0014, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'd5,   32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC0DE_0005};

        // Reset state, then release away from a clock edge.
        #2;
        check_all_zero("reset_state");
        #20;
        rst_n = 1'b1;
        #1;
        chk("release_no_rvalid", {62'h0, bus.i_rvalid, bus.d_rvalid}, 64'h0);
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            bus.i_req = vecs[k].i_req;  bus.i_addr = vecs[k].i_addr;
            bus.d_req = vecs[k].d_req;  bus.d_we = vecs[k].d_we;  bus.d_be = vecs[k].d_be;
            bus.d_addr = vecs[k].d_addr; bus.d_wdata = vecs[k].d_wdata;
            @(negedge clk);
            chk($sformatf("vec%0d_i_gnt", k), {63'h0, bus.i_gnt}, {63'h0, vecs[k].e_i_gnt});
            chk($sformatf("vec%0d_d_gnt", k), {63'h0, bus.d_gnt}, {63'h0, vecs[k].e_d_gnt});
            chk($sformatf("vec%0d_m_en", k), {63'h0, bus.m_en}, {63'h0, vecs[k].e_m_en});
            chk($sformatf("vec%0d_m_we", k), {63'h0, bus.m_we}, {63'h0, vecs[k].e_m_we});
            chk($sformatf("vec%0d_m_be", k), {60'h0, bus.m_be}, {60'h0, vecs[k].e_m_be});
            chk($sformatf("vec%0d_m_addr", k), {56'h0, bus.m_addr}, {56'h0, vecs[k].e_m_addr});
            chk($sformatf("vec%0d_m_wdata", k), {32'h0, bus.m_wdata}, {32'h0, vecs[k].e_m_wdata});
            finish_cycle();
            drive_idle();
            @(negedge clk);
            chk($sformatf("vec%0d_i_rvalid", k), {63'h0, bus.i_rvalid}, {63'h0, vecs[k].e_i_rv});
            chk($sformatf("vec%0d_i_err", k), {63'h0, bus.i_err}, {63'h0, vecs[k].e_i_err});
            chk($sformatf("vec%0d_i_rdata", k), {32'h0, bus.i_rdata}, {32'h0, vecs[k].e_i_rd});
            chk($sformatf("vec%0d_d_rvalid", k), {63'h0, bus.d_rvalid}, {63'h0, vecs[k].e_d_rv});
            chk($sformatf("vec%0d_d_err", k), {63'h0, bus.d_err}, {63'h0, vecs[k].e_d_err});
            chk($sformatf("vec%0d_d_rdata", k), {32'h0, bus.d_rdata}, {32'h0, vecs[k].e_d_rd});
            finish_cycle();
        end

        // Contention: a lone fetch first so both builds start from a known owner.
        bus.i_req = 1; bus.i_addr = 32'h0;
        @(negedge clk);
        finish_cycle();
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = (k % (MAX_STALL + 1) == MAX_STALL) ? 2'b10 : 2'b01;
`endif
            chk($sformatf("contention_cycle%0d", k), {62'h0, bus.i_gnt, bus.d_gnt}, {62'h0, exp_g});
            finish_cycle();
        end
        drive_idle();
        @(negedge clk);
        finish_cycle();

        // Reset mid-operation: a load and a store to word 4, cut off before the edge.
        for (int k = 0; k < 2; k++) begin
            bus.d_req = 1; bus.d_we = (k == 1); bus.d_be = 4'hF;
            bus.d_addr = 32'h10; bus.d_wdata = 32'h0;
            @(negedge clk);
            chk($sformatf("midop%0d_granted", k), {62'h0, bus.d_gnt, bus.m_en}, 64'h3);
            #2;
            rst_n = 1'b0;
            #1;
            check_all_zero($sformatf("midop%0d_in_reset", k));
            @(posedge clk);
            @(negedge clk);
            drive_idle();
            rst_n = 1'b1;
            #1;
            chk($sformatf("midop%0d_no_rvalid", k), {62'h0, bus.i_rvalid, bus.d_rvalid}, 64'h0);
            model_reset();
            @(posedge clk);
            #1;
            @(negedge clk);
            finish_cycle();
            chk($sformatf("midop%0d_mem4", k), {32'h0, mem[4]}, {32'h0, 32'hDEAD_BEEF});
        end

        // Async reset under random traffic.
        bus.i_req = 1; bus.i_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_be = 4'($urandom_range(1, 15));
        bus.d_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; bus.d_wdata = $urandom;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        chk("async_reset_release_no_rvalid", {62'h0, bus.i_rvalid, bus.d_rvalid}, 64'h0);
        model_reset();
        @(posedge clk);
        #1;

        // Random traffic; requesters hold their request until granted.
        for (int c = 0; c < 400; c++) begin
            if (!(bus.i_req && m_win != 1)) begin
                bus.i_req = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 9))
                    0:       bus.i_addr = $urandom | 32'h0000_0400;
                    1:       bus.i_addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                    default: bus.i_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                endcase
            end
            if (!(bus.d_req && m_win != 2)) begin
                bus.d_req   = ($urandom_range(0, 9) < 7);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_be    = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                bus.d_addr  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_0400)
                                                           : {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
                bus.d_wdata = $urandom;
            end
            @(negedge clk);
            finish_cycle();
        end
        drive_idle();
        @(negedge clk);
        finish_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
